// File: rtl/fixed_to_float_stream_if.sv
// rtl/fixed_to_float_stream_if.sv - stream bundle for the fixed-to-float converter
//
// Purpose: carries the input sample stream and the result stream of
// fixed_to_float_stream as one interface.
// Ports (signals):
//   in_valid / in_ready / in_data[IN_W] / in_tag[TAG_W]   sample stream
//   out_valid / out_ready / out_data[32] / out_tag[TAG_W] /
//   out_inexact                                            result stream
// Modports: slave = converter side, master = producer/consumer side.
// IN_W and TAG_W must match the parameters of the attached converter.

interface fixed_to_float_stream_if #(
  parameter int IN_W  = 24,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_inexact;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_inexact
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_inexact
  );
endinterface

// File: rtl/fixed_to_float_stream.sv
// rtl/fixed_to_float_stream.sv - 3-stage two's-complement fixed-point to IEEE-754 single converter
//
// Purpose: converts a stream of IN_W-bit two's-complement values with FRAC_W
// fraction bits into single-precision floats, carrying a TAG_W sideband tag.
// Pipeline: S1 sign/magnitude, S2 leading-one detect + normalise, S3 round/pack.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   s        fixed_to_float_stream_if.slave (in_* sample stream, out_* result stream)
// Configuration macro: FX2FP_ROUND_NEAREST_EN
//   defined   -> round to nearest, ties to even
//   undefined -> truncate toward zero in magnitude
// out_inexact reports discarded non-zero bits in both modes.

module fixed_to_float_stream #(
  parameter int IN_W   = 24,
  parameter int FRAC_W = 22,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  fixed_to_float_stream_if.slave    s
);

  if (IN_W < 8 || IN_W > 64 || FRAC_W < 0 || FRAC_W > IN_W - 1 ||
      TAG_W < 1 || TAG_W > 16) begin : g_bad_params
    $error("fixed_to_float_stream: IN_W/FRAC_W/TAG_W out of legal range");
  end

  localparam int PW    = 7;          // holds bit positions up to 63
  localparam int EXT_W = IN_W + 23;  // bits below the leading one, padded to 23+ bits

  // Whole pipeline moves as one; a stalled output freezes every stage.
  logic advance;
  assign advance  = !s.out_valid || s.out_ready;
  assign s.in_ready = advance;

  // ---------------- S1: sign / magnitude ----------------
  logic             s1_valid;
  logic             s1_sign;
  logic [IN_W-1:0]  s1_mag;
  logic [TAG_W-1:0] s1_tag;

  // Negating in IN_W bits maps the most negative value onto 2^(IN_W-1),
  // which is still the correct unsigned magnitude.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_tag   <= '0;
    end else if (advance) begin
      s1_valid <= s.in_valid;
      s1_sign  <= s.in_data[IN_W-1];
      s1_mag   <= s.in_data[IN_W-1] ? -s.in_data : s.in_data;
      s1_tag   <= s.in_tag;
    end
  end

  // ---------------- S2: leading-one detect / normalise ----------------
  logic [PW-1:0]   lz_p;
  logic [PW-1:0]   lz_sh;
  logic [IN_W-1:0] norm_n;
  logic [7:0]      exp_n;

  always_comb begin
    lz_p = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) lz_p = PW'(i);
    end
    lz_sh  = PW'(IN_W - 1) - lz_p;
    norm_n = s1_mag << lz_sh;
    exp_n  = 8'(127 - FRAC_W) + 8'(lz_p);
  end

  logic             s2_valid;
  logic             s2_sign;
  logic             s2_zero;
  logic [7:0]       s2_exp;
  logic [IN_W-1:0]  s2_norm;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b1;
      s2_exp   <= '0;
      s2_norm  <= '0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= ~|s1_mag;
      s2_exp   <= exp_n;
      s2_norm  <= norm_n;
      s2_tag   <= s1_tag;
    end
  end

  // ---------------- S3: round / pack ----------------
  logic [EXT_W-1:0] ext;
  logic [22:0]      frac_t;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [23:0]      frac_r;
  logic [7:0]       exp_r;
  logic [22:0]      frac_p;
  logic [31:0]      packed_n;
  logic             inexact_n;

  // The implicit leading one (top bit of s2_norm) is dropped; whatever lies
  // below the 23 kept fraction bits is the guard bit followed by sticky bits.
  // When the leading one sits at bit 23 or lower those bits are all zero.
  always_comb begin
    ext    = {s2_norm[IN_W-2:0], 24'd0};
    frac_t = ext[EXT_W-1 -: 23];
    guard  = ext[EXT_W-24];
    sticky = |ext[EXT_W-25:0];
`ifdef FX2FP_ROUND_NEAREST_EN
    round_up = guard & (sticky | frac_t[0]);
`else
    round_up = 1'b0;
`endif
    frac_r = {1'b0, frac_t} + {23'd0, round_up};
    // Carry out of the fraction bumps the exponent; the fraction wraps to 0.
    exp_r  = s2_exp + {7'd0, frac_r[23]};
    frac_p = frac_r[23] ? 23'd0 : frac_r[22:0];
    packed_n  = s2_zero ? 32'd0 : {s2_sign, exp_r, frac_p};
    inexact_n = !s2_zero && (guard || sticky);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s.out_valid   <= 1'b0;
      s.out_data    <= '0;
      s.out_tag     <= '0;
      s.out_inexact <= 1'b0;
    end else if (advance) begin
      s.out_valid   <= s2_valid;
      s.out_data    <= packed_n;
      s.out_tag     <= s2_tag;
      s.out_inexact <= inexact_n;
    end
  end

endmodule

// File: doc/fixed_to_float_stream.md
FIXED_TO_FLOAT_STREAM -- requirements
Module: fixed_to_float_stream

Interface
REQ-001 SHALL have parameter IN_W, default 24, input word width in bits (legal 8..64).
REQ-002 SHALL have parameter FRAC_W, default 22, fractional bits of the input (legal 0..IN_W-1).
REQ-003 SHALL have parameter TAG_W, default 4, sideband tag width carried alongside each sample (legal 1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input sample present.
REQ-007 SHALL have port in_ready  output  1  block accepts the input sample this cycle.
REQ-008 SHALL have port in_data  input  IN_W  two's-complement fixed-point value, FRAC_W fraction bits.
REQ-009 SHALL have port in_tag  input  TAG_W  opaque sideband, returned unchanged with the result.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL have port out_data  output  32  IEEE-754 single-precision result.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the sample producing out_data.
REQ-014 SHALL have port out_inexact  output  1  result is not exactly equal to the input value.

Function
REQ-015 SHALL transfer on a port when valid and ready are both high on a rising clk edge.
REQ-016 SHALL be a 3-stage pipeline: S1 sign/magnitude, S2 leading-one detect and normalise, S3 round/pack.
REQ-017 SHALL produce a result with out_valid high exactly 3 cycles after acceptance when out_ready is continuously high.
REQ-018 SHALL sustain one accepted sample per cycle with out_ready held high.
REQ-019 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-020 SHALL hold out_data, out_tag, out_inexact, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL preserve sample order and never drop or duplicate a sample; stage bubbles propagate as invalid slots.
REQ-022 SHALL compute magnitude M = |in_data| in IN_W bits, so the most negative input converts exactly.
REQ-023 SHALL, for M = 0, output 0x00000000 (positive zero, including sign) with out_inexact = 0.
REQ-024 SHALL, for M != 0 with leading one at bit p, output sign = in_data[IN_W-1], biased exponent = 127 + p - FRAC_W, fraction = the bits below p left-aligned into 23 bits.
REQ-025 SHALL zero-fill the fraction LSBs when p <= 23 (exact, out_inexact = 0).
REQ-026 SHALL, when p > 23, reduce the discarded bits per REQ-033/034 and set out_inexact = 1 if any discarded bit is 1.
REQ-027 SHALL increment the exponent and clear the fraction when rounding carries out of the 23-bit fraction.
REQ-028 SHALL reject at elaboration any IN_W/FRAC_W outside the legal ranges (exponent range then always within 1..254; no subnormal/Inf/NaN output).

Reset
REQ-029 SHALL, on reset_n low at a clock edge, clear all stage valid flags; out_valid = 0 the following cycle.
REQ-030 SHALL drive out_data = 0, out_tag = 0, out_inexact = 0 after reset.
REQ-031 SHALL discard every in-flight sample when reset is asserted mid-operation; none re-appears after release.
REQ-032 SHALL hold in_ready = 1 during and after reset (pipeline empty).

Configuration
REQ-033 SHALL, with macro FX2FP_ROUND_NEAREST_EN defined, round to nearest, ties to even, using guard bit and OR of remaining discarded bits.
REQ-034 SHALL, without FX2FP_ROUND_NEAREST_EN, truncate toward zero in magnitude (discard bits dropped, no carry), out_inexact still reported.

Verification
REQ-035 SHALL cover defaults: in_data 0x400000 -> 0x3F800000; 0xC00000 -> 0xBF800000; 0x800000 -> 0xC0000000; 0x000001 -> 0x34800000; 0x000000 -> 0x00000000; all inexact 0.
REQ-036 SHALL cover IN_W=32, FRAC_W=0: 0x01000003 -> 0x4B800002 with macro, 0x4B800001 without; out_inexact = 1 both.
REQ-037 SHALL cover rounding carry, IN_W=32, FRAC_W=0: 0x01FFFFFF -> 0x4C000000 with macro, 0x4BFFFFFF without.
REQ-038 SHALL cover backpressure: stream 8 tagged samples, out_ready low for 5 cycles mid-stream -> outputs held stable, in_ready low while stalled, all 8 in order with matching tags.
REQ-039 SHALL cover reset mid-stream: reset_n low 1 cycle with 3 samples in flight -> out_valid 0 next cycle, no stale result after release, next accepted sample emerges after 3 cycles.
